// File: rtl/video_linescaler.sv
// ============================================================================
//  Module   : video_linescaler
//  Purpose  : Ping-pong line buffer with Q8.8 horizontal scaler, centring
//             window, vertical line repeat and VGA timing regeneration.
//             Optional `SCANLINE_EN dims odd output lines by 50%.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module video_linescaler #(
    parameter int PIX_W    = 15,
    parameter int SRC_W    = 512,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_REP    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    input  logic             in_sol,
    input  logic             in_sof,
    input  logic [15:0]      h_step,
    input  logic [10:0]      h_offset,
    input  logic [10:0]      out_width,
    output logic [PIX_W-1:0] VGA_PIX,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK,
    output logic [10:0]      VGA_HCOUNTER,
    output logic [10:0]      VGA_VCOUNTER,
    output logic [15:0]      underrun_cnt,
    output logic             frame_start
);

    localparam int c_XW = $clog2(SRC_W + 1);
    localparam int c_AW = $clog2(2 * SRC_W);
    localparam int c_RW = (V_REP > 1) ? $clog2(V_REP) : 1;

    localparam logic [10:0] c_H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] c_V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [c_XW-1:0] c_SRC_WX    = c_XW'(SRC_W);
    localparam logic [c_XW-1:0] c_SRC_LASTX = c_XW'(SRC_W - 1);
    localparam logic [15:0]     c_SRC_W16   = 16'(SRC_W);
    localparam logic [c_AW-1:0] c_BANK1     = c_AW'(SRC_W);
    localparam logic [c_RW-1:0] c_REP_LAST  = c_RW'(V_REP - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] mem_q [0:2*SRC_W-1];
    logic [PIX_W-1:0] rdata_q;

    logic [10:0]     h_q, h_d;
    logic [10:0]     v_q, v_d;
    logic [c_RW-1:0] rep_q, rep_d;
    logic            rd_bank_q, rd_bank_d;
    logic            rd_valid_q, rd_valid_d;
    logic            full_q, full_d;
    logic [c_XW-1:0] wr_x_q, wr_x_d;
    logic            sof_pending_q, sof_pending_d;
    logic [15:0]     underrun_q, underrun_d;
    logic [23:0]     acc_q, acc_d;

    logic             en1_q, hs1_q, vs1_q, blank1_q, fs1_q;
    logic [10:0]      h1_q, v1_q;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [c_XW-1:0] w_wx;
    logic            w_we;
    logic            w_wr_last;
    logic [c_AW-1:0] w_waddr;

    always_comb begin
        w_wx      = in_sol ? '0 : wr_x_q;
        w_we      = in_valid && (in_sol || (wr_x_q < c_SRC_WX));
        w_wr_last = w_we && (w_wx == c_SRC_LASTX);
        w_waddr   = c_AW'(w_wx) + (rd_bank_q ? '0 : c_BANK1);
    end

    // ------------------------------------------------------------------
    // Read-side timing, frame lock and line claim
    // ------------------------------------------------------------------
    logic            w_h_wrap;
    logic            w_lock;
    logic [10:0]     w_v_next;
    logic            w_cur_act;
    logic            w_next_act;
    logic [c_RW-1:0] w_rep_next;
    logic            w_claim;

    always_comb begin
        w_h_wrap   = (h_q == c_H_LAST);
        w_cur_act  = (v_q < c_V_ACT);
        w_lock     = sof_pending_q && !w_cur_act;
        if (w_lock || (v_q == c_V_LAST)) begin
            w_v_next = '0;
        end else begin
            w_v_next = v_q + 11'd1;
        end
        w_next_act = (w_v_next < c_V_ACT);
        // rep_q is the repeat index of the line currently being scanned
        if (!w_cur_act || (rep_q == c_REP_LAST)) begin
            w_rep_next = '0;
        end else begin
            w_rep_next = rep_q + c_RW'(1);
        end
        w_claim    = w_h_wrap && w_next_act && (w_rep_next == '0);
    end

    // ------------------------------------------------------------------
    // Picture window and DDA
    // ------------------------------------------------------------------
    logic [11:0]     w_win_end;
    logic            w_win;
    logic [23:0]     w_acc_base;
    logic [15:0]     w_src_x;
    logic            w_in_range;
    logic [c_AW-1:0] w_raddr;
    logic            w_pix_en;
    logic            w_hs0, w_vs0, w_blank0, w_fs0;

    always_comb begin
        w_win_end  = {1'b0, h_offset} + {1'b0, out_width};
        w_win      = w_cur_act && (h_q >= h_offset) &&
                     ({1'b0, h_q} < w_win_end) && (h_q < c_H_ACT);
        w_acc_base = (h_q == h_offset) ? 24'd0 : acc_q;
        w_src_x    = w_acc_base[23:8];
        w_in_range = (w_src_x < c_SRC_W16);
        w_raddr    = (w_in_range ? c_AW'(w_src_x) : '0) + (rd_bank_q ? c_BANK1 : '0);
        w_pix_en   = w_win && w_in_range && rd_valid_q;
        w_hs0      = !((h_q >= c_HS_START) && (h_q < c_HS_END));
        w_vs0      = !((v_q >= c_VS_START) && (v_q < c_VS_END));
        w_blank0   = !((h_q < c_H_ACT) && w_cur_act);
        w_fs0      = (h_q == '0) && (v_q == '0);
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        h_d           = w_h_wrap ? 11'd0 : h_q + 11'd1;
        v_d           = w_h_wrap ? w_v_next : v_q;
        rep_d         = w_h_wrap ? w_rep_next : rep_q;
        rd_bank_d     = rd_bank_q;
        rd_valid_d    = rd_valid_q;
        full_d        = full_q;
        wr_x_d        = wr_x_q;
        sof_pending_d = sof_pending_q;
        underrun_d    = underrun_q;
        acc_d         = w_win ? (w_acc_base + {8'd0, h_step}) : w_acc_base;

        if (in_valid) begin
            if (in_sol) begin
                wr_x_d = c_XW'(1);
                full_d = 1'b0;
            end else if (wr_x_q < c_SRC_WX) begin
                wr_x_d = wr_x_q + c_XW'(1);
            end
        end
        if (w_wr_last) begin
            full_d = 1'b1;
        end

        if (w_claim) begin
            if (full_q) begin
                rd_bank_d  = ~rd_bank_q;
                rd_valid_d = 1'b1;
                full_d     = 1'b0;
            end else if (underrun_q != 16'hFFFF) begin
                underrun_d = underrun_q + 16'd1;
            end
        end

        if (w_h_wrap && w_lock) begin
            sof_pending_d = 1'b0;
        end
        // a fresh sof wins over a lock consuming the previous one
        if (in_valid && in_sol && in_sof) begin
            sof_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_q           <= '0;
            v_q           <= '0;
            rep_q         <= '0;
            rd_bank_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            full_q        <= 1'b0;
            wr_x_q        <= '0;
            sof_pending_q <= 1'b0;
            underrun_q    <= '0;
            acc_q         <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            rep_q         <= rep_d;
            rd_bank_q     <= rd_bank_d;
            rd_valid_q    <= rd_valid_d;
            full_q        <= full_d;
            wr_x_q        <= wr_x_d;
            sof_pending_q <= sof_pending_d;
            underrun_q    <= underrun_d;
            acc_q         <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Line buffer RAM (no reset so it maps onto block RAM)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[w_waddr] <= in_pixel;
        end
        rdata_q <= mem_q[w_raddr];
    end

    // ------------------------------------------------------------------
    // Stage 1: controls travel alongside the RAM read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en1_q    <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            blank1_q <= 1'b1;
            fs1_q    <= 1'b0;
            h1_q     <= '0;
            v1_q     <= '0;
        end else begin
            en1_q    <= w_pix_en;
            hs1_q    <= w_hs0;
            vs1_q    <= w_vs0;
            blank1_q <= w_blank0;
            fs1_q    <= w_fs0;
            h1_q     <= h_q;
            v1_q     <= v_q;
        end
    end

    logic [PIX_W-1:0] w_pix_out;

`ifdef SCANLINE_EN
    localparam int c_FW = PIX_W / 3;
    logic [PIX_W-1:0] w_dim;

    for (genvar f = 0; f < 3; f++) begin : g_field
        assign w_dim[f*c_FW +: c_FW] = {1'b0, rdata_q[f*c_FW+1 +: c_FW-1]};
    end
    if (PIX_W > 3 * c_FW) begin : g_rest
        assign w_dim[PIX_W-1:3*c_FW] = rdata_q[PIX_W-1:3*c_FW];
    end
    assign w_pix_out = v1_q[0] ? w_dim : rdata_q;
`else
    assign w_pix_out = rdata_q;
`endif

    // ------------------------------------------------------------------
    // Stage 2: registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            VGA_PIX      <= '0;
            VGA_HS       <= 1'b1;
            VGA_VS       <= 1'b1;
            VGA_BLANK    <= 1'b1;
            VGA_HCOUNTER <= '0;
            VGA_VCOUNTER <= '0;
            frame_start  <= 1'b0;
        end else begin
            VGA_PIX      <= en1_q ? w_pix_out : '0;
            VGA_HS       <= hs1_q;
            VGA_VS       <= vs1_q;
            VGA_BLANK    <= blank1_q;
            VGA_HCOUNTER <= h1_q;
            VGA_VCOUNTER <= v1_q;
            frame_start  <= fs1_q;
        end
    end

    assign underrun_cnt = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_video_linescaler.sv
// ============================================================================
//  Module   : tb_video_linescaler
//  Purpose  : Directed self-checking bench on a shrunken raster
//             (56x18 total, 40x12 active, 16-px source lines).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_video_linescaler;

    localparam int PIX_W = 15;
    localparam int LIM   = 2500;

`ifdef SCANLINE_EN
    localparam logic [31:0] EXP_ODD_10E  = 32'h0087;
    localparam logic [31:0] EXP_ODD_7FFF = 32'h3DEF;
`else
    localparam logic [31:0] EXP_ODD_10E  = 32'h010E;
    localparam logic [31:0] EXP_ODD_7FFF = 32'h7FFF;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [PIX_W-1:0] in_pixel;
    logic             in_valid, in_sol, in_sof;
    logic [15:0]      h_step;
    logic [10:0]      h_offset, out_width;
    logic [PIX_W-1:0] VGA_PIX;
    logic             VGA_HS, VGA_VS, VGA_BLANK;
    logic [10:0]      VGA_HCOUNTER, VGA_VCOUNTER;
    logic [15:0]      underrun_cnt;
    logic             frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_linescaler #(
        .PIX_W(PIX_W), .SRC_W(16),
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .V_REP(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_sol(in_sol), .in_sof(in_sof),
        .h_step(h_step), .h_offset(h_offset), .out_width(out_width),
        .VGA_PIX(VGA_PIX), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
        .VGA_HCOUNTER(VGA_HCOUNTER), .VGA_VCOUNTER(VGA_VCOUNTER),
        .underrun_cnt(underrun_cnt), .frame_start(frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!((int'(VGA_HCOUNTER) == h) && (int'(VGA_VCOUNTER) == v)) && (n < LIM)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < LIM) else begin
            errors++;
            $error("FAIL wait_pos(%0d,%0d) observed=timeout expected=reached", h, v);
        end
    endtask

    task automatic write_line(input logic [PIX_W-1:0] base, input int n,
                              input bit inc, input bit sof);
        for (int i = 0; i < n; i++) begin
            in_pixel = inc ? base + PIX_W'(i) : base;
            in_valid = 1'b1;
            in_sol   = (i == 0);
            in_sof   = sof && (i == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_sol   = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_pixel  = '0;
        in_valid  = 1'b0;
        in_sol    = 1'b0;
        in_sof    = 1'b0;
        h_step    = 16'h0100;
        h_offset  = 11'd4;
        out_width = 11'd16;
        repeat (5) @(negedge clk);

        chk("rst_hs",    32'(VGA_HS),       32'd1);
        chk("rst_vs",    32'(VGA_VS),       32'd1);
        chk("rst_blank", 32'(VGA_BLANK),    32'd1);
        chk("rst_pix",   32'(VGA_PIX),      32'd0);
        chk("rst_hcnt",  32'(VGA_HCOUNTER), 32'd0);
        chk("rst_vcnt",  32'(VGA_VCOUNTER), 32'd0);
        chk("rst_under", 32'(underrun_cnt), 32'd0);
        chk("rst_fs",    32'(frame_start),  32'd0);

        reset_n = 1'b1;
        @(negedge clk);
        chk("fs_lat1", 32'(frame_start), 32'd0);
        @(negedge clk);
        chk("fs_lat2",  32'(frame_start),  32'd1);
        chk("fs_hcnt",  32'(VGA_HCOUNTER), 32'd0);
        chk("fs_blank", 32'(VGA_BLANK),    32'd0);

        // Horizontal timing, empty buffer
        wait_pos(10, 0); chk("pix_nodata",  32'(VGA_PIX),   32'd0);
        wait_pos(39, 0); chk("blank_h39",   32'(VGA_BLANK), 32'd0);
        wait_pos(40, 0); chk("blank_h40",   32'(VGA_BLANK), 32'd1);
        wait_pos(43, 0); chk("hs_h43",      32'(VGA_HS),    32'd1);
        wait_pos(44, 0); chk("hs_h44",      32'(VGA_HS),    32'd0);
        wait_pos(51, 0); chk("hs_h51",      32'(VGA_HS),    32'd0);
        wait_pos(52, 0); chk("hs_h52",      32'(VGA_HS),    32'd1);
        wait_pos(5, 1);  chk("under_l1",    32'(underrun_cnt), 32'd0);
        wait_pos(5, 2);  chk("under_l2",    32'(underrun_cnt), 32'd1);

        // Vertical timing
        wait_pos(0, 12);  chk("blank_v12", 32'(VGA_BLANK), 32'd1);
        wait_pos(0, 13);  chk("vs_v13",    32'(VGA_VS),    32'd1);
        wait_pos(0, 14);  chk("vs_v14",    32'(VGA_VS),    32'd0);
        wait_pos(55, 15); chk("vs_v15",    32'(VGA_VS),    32'd0);
        wait_pos(0, 16);  chk("vs_v16",    32'(VGA_VS),    32'd1);
        wait_pos(0, 0);   chk("fs_frame2", 32'(frame_start), 32'd1);
        wait_pos(1, 0);
        chk("fs_once",      32'(frame_start),  32'd0);
        chk("under_frame2", 32'(underrun_cnt), 32'd6);

        // Ramp line, 1:1 scale, window 4..19
        write_line(15'h0100, 16, 1'b1, 1'b0);
        wait_pos(3, 2);  chk("win_left",   32'(VGA_PIX), 32'd0);
        wait_pos(4, 2);  chk("win_first",  32'(VGA_PIX), 32'h100);
        wait_pos(19, 2); chk("win_last",   32'(VGA_PIX), 32'h10F);
        wait_pos(20, 2); chk("win_right",  32'(VGA_PIX), 32'd0);
        wait_pos(4, 3);  chk("rep_line3",  32'(VGA_PIX), 32'h100);
        wait_pos(10, 3); chk("rep_line3b", 32'(VGA_PIX), 32'h106);
        wait_pos(4, 4);
        chk("reuse_pix",   32'(VGA_PIX),      32'h100);
        chk("reuse_under", 32'(underrun_cnt), 32'd7);

        // Upscale 2x, full width
        h_step    = 16'h0080;
        h_offset  = 11'd0;
        out_width = 11'd40;
        wait_pos(0, 6);  chk("up_c0",    32'(VGA_PIX), 32'h100);
        wait_pos(1, 6);  chk("up_c1",    32'(VGA_PIX), 32'h100);
        wait_pos(2, 6);  chk("up_c2",    32'(VGA_PIX), 32'h101);
        wait_pos(31, 6); chk("up_c31",   32'(VGA_PIX), 32'h10F);
        wait_pos(32, 6); chk("up_clamp", 32'(VGA_PIX), 32'd0);

        // Downscale 2x with source clamp
        h_step = 16'h0200;
        wait_pos(7, 8); chk("dn_c7",    32'(VGA_PIX), 32'h10E);
        wait_pos(8, 8); chk("dn_clamp", 32'(VGA_PIX), 32'd0);
        wait_pos(7, 9); chk("odd_line", 32'(VGA_PIX), EXP_ODD_10E);

        // Early sof during active lines, plus overlong source line
        h_step = 16'h0100;
        wait_pos(1, 10);
        write_line(15'h7FFF, 20, 1'b0, 1'b1);
        wait_pos(2, 11);  chk("no_tear",  32'(VGA_PIX),      32'h102);
        wait_pos(55, 12); chk("lock_v12", 32'(VGA_VCOUNTER), 32'd12);
        @(negedge clk);
        chk("lock_vcnt", 32'(VGA_VCOUNTER), 32'd0);
        chk("lock_fs",   32'(frame_start),  32'd1);
        wait_pos(5, 0);
        chk("new_even", 32'(VGA_PIX),     32'h7FFF);
        chk("fs_pulse", 32'(frame_start), 32'd0);
        wait_pos(5, 1);  chk("new_odd",    32'(VGA_PIX),      EXP_ODD_7FFF);
        wait_pos(6, 1);  chk("lock_under", 32'(underrun_cnt), 32'd10);
        wait_pos(20, 1); chk("new_clamp",  32'(VGA_PIX),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
